// File: rtl/tdm_demux_8ch.sv
// -----------------------------------------------------------------------------
// tdm_demux_8ch
//
// Receive end of the 8:1 time-division serial channel. Accepts one W-bit
// sample per valid cycle, aligns to the frame-sync marker (slot 0), and steers
// successive samples into slots 0..7. When slot 7 arrives the complete frame
// is published on ch_out with a one-cycle frame_valid strobe. Framing
// violations pulse sync_err and are recovered automatically.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst_n        synchronous active-low reset
//   din          W-bit sample from the line
//   din_valid    din holds a sample this cycle
//   sync         din is the slot-0 sample of a frame (only when din_valid=1)
//   ch_out       last complete frame, slot i at bits [i*W +: W]
//   frame_valid  one-cycle pulse: ch_out just updated
//   slot         slot index the next accepted sample will occupy
//   locked       receiver is aligned to the frame (LOCK state)
//   sync_err     one-cycle pulse on a framing violation
// -----------------------------------------------------------------------------
module tdm_demux_8ch #(
  parameter int unsigned W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           sync,
  output logic [8*W-1:0] ch_out,
  output logic           frame_valid,
  output logic [2:0]     slot,
  output logic           locked,
  output logic           sync_err
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          slot_q, slot_d;
  logic [7:0][W-1:0]   shadow_q, shadow_d;
  logic [7:0][W-1:0]   ch_out_q, ch_out_d;
  logic                frame_valid_q, frame_valid_d;
  logic                sync_err_q, sync_err_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d       = state_q;
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    ch_out_d      = ch_out_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          // Non-sync samples are silently dropped while hunting.
          if (sync) begin
            shadow_d[0] = din;
            slot_d      = 3'd1;
            state_d     = LOCK;
          end
        end

        LOCK: begin
          if (sync) begin
            // Sync mid-frame (including at slot 7) is an early-sync error:
            // drop the partial frame and restart on this sample.
            sync_err_d  = (slot_q != 3'd0);
            shadow_d[0] = din;
            slot_d      = 3'd1;
          end else if (slot_q == 3'd0) begin
            // A frame must start with sync; lost alignment, go hunting.
            sync_err_d = 1'b1;
            slot_d     = 3'd0;
            state_d    = HUNT;
          end else if (slot_q == 3'd7) begin
            // Slot 7 bypasses the shadow and lands in ch_out directly.
            ch_out_d      = {din, shadow_q[6:0]};
            frame_valid_d = 1'b1;
            slot_d        = 3'd0;
          end else begin
            shadow_d[slot_q] = din;
            slot_d           = slot_q + 3'd1;
          end
        end

        default: state_d = HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      slot_q        <= 3'd0;
      // NOTE: the shadow frame store is cleared on reset too, so its contents
      // are deterministic even though they are only read while locked.
      shadow_q      <= '0;
      ch_out_q      <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      ch_out_q      <= ch_out_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign ch_out      = ch_out_q;
  assign frame_valid = frame_valid_q;
  assign slot        = slot_q;
  assign locked      = (state_q == LOCK);
  assign sync_err    = sync_err_q;

endmodule

// File: doc/tdm_demux_8ch.md
# tdm_demux_8ch

Sequential 1-to-8 time-division demultiplexer: the receive end of the team's 8:1 mux-based serial channel. It takes one sample per valid cycle from a shared line, aligns to a frame-sync marker, and steers successive samples into channel slots 0..7 using an internal slot counter. It publishes a complete, registered 8-channel frame with a one-cycle strobe. Sync loss is detected and recovered automatically.

## Interface
- W, default 1, sample width per channel (bits)
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- din  input  W  serial sample from the line
- din_valid  input  1  din holds a sample this cycle
- sync  input  1  qualifies din as the slot-0 sample of a frame; ignored when din_valid=0
- ch_out  output  8*W  last complete frame; slot i at bits [i*W +: W]
- frame_valid  output  1  one-cycle pulse: ch_out just updated
- slot  output  3  slot index the next accepted sample will occupy
- locked  output  1  FSM is in LOCK
- sync_err  output  1  one-cycle pulse on a framing violation

## Operation
- Internal state:
  - FSM {HUNT, LOCK}
  - 3-bit slot counter
  - 8×W shadow register for the frame being assembled
- Accepted sample = din_valid=1 at a rising edge; cycles with din_valid=0 change nothing.
- HUNT:
  - Samples with sync=0 are discarded; no error is raised.
  - valid & sync: shadow[0]←din, slot←1, go to LOCK.
- LOCK, valid & sync=0 & slot≠0: shadow[slot]←din, slot←slot+1.
- LOCK, valid & slot=7 (sync=0) completes the frame:
  - ch_out←{din, shadow[6:0]}; the slot-7 sample goes straight to ch_out in the same edge.
  - frame_valid pulses; slot wraps to 0; FSM stays in LOCK.
- LOCK, valid & sync=1 & slot=0: normal frame start. shadow[0]←din, slot←1.
- LOCK, valid & sync=1 & slot≠0 (early sync):
  - sync_err pulses; the partial frame is discarded.
  - shadow[0]←din, slot←1; FSM stays in LOCK (immediate resync).
- LOCK, valid & sync=0 & slot=0 (missing sync):
  - sync_err pulses; sample discarded; slot stays 0; go to HUNT.
- ch_out changes only on frame completion. A discarded partial frame never reaches ch_out; ch_out keeps the previous frame.
- Shadow contents are don't-care outside LOCK. Slots are always written in order, so no stale-slot leakage is possible.
- locked=1 iff FSM=LOCK.

## Timing
- Reset (rst_n=0 at an edge):
  - ch_out=0, frame_valid=0, sync_err=0, slot=0, locked=0, FSM=HUNT, shadow=0.
  - Reset overrides din_valid/sync in the same cycle.
- Reset mid-frame discards all partial data. The first frame after reset requires a fresh sync.
- Latency: ch_out and frame_valid are registered and visible the cycle after the edge that accepts the slot-7 sample.
- frame_valid and sync_err are single-cycle pulses, never held. Both are 0 in any cycle following a non-accepting edge.
- Back-to-back frames at din_valid=1 every cycle give frame_valid every 8th cycle with no bubble: the slot-0 sample of frame N+1 may immediately follow slot 7 of frame N.
- Gaps (din_valid=0) anywhere inside a frame are legal and only stretch it.
- slot updates on the same edge as the accepting sample. slot=0 whenever FSM=HUNT.
- No simultaneous frame_valid and sync_err is possible: slot 7 with sync=1 is an early-sync error, not a completion.

## Test plan
- **Reset values:** assert rst_n=0 for 2 cycles with din_valid=1, sync=1 → all outputs 0, locked=0, slot=0; release → locked stays 0 until the first valid&sync.
- **Basic frame, W=1:** slots 0..7 = 1,0,1,1,0,0,1,0 on consecutive cycles, sync with the first → next cycle ch_out=8'h4D, frame_valid=1 for exactly one cycle, locked=1, slot=0.
- **Back-to-back with gaps, W=4:** frame A = 4'h0..4'h7, then frame B = 4'hF..4'h8 with din_valid=0 inserted after slots 2 and 5 of B → ch_out=32'h76543210, then 32'h89ABCDEF. Two frame_valid pulses; the second is delayed by 2 cycles.
- **Early sync:** send slots 0..3, then valid&sync → sync_err pulse, slot=1, ch_out unchanged. The next 7 samples complete the new frame with frame_valid.
- **Missing sync:** after a good frame, send valid with sync=0 → sync_err pulse, locked=0, slot=0. Further non-sync samples → no errors, no frame_valid.
- **Mid-frame reset:** after 5 slots, rst_n=0 for 1 cycle → ch_out=0, FSM=HUNT. Sending 3 samples without sync → no frame_valid.
